nb_shift_pipe: RTL and testbench

//  Parametrised register chain generalising the 3-register non-blocking a->b->c chain and the two-register swap.
//  - DEPTH stages, each WIDTH bits wide, with a valid bit per stage.
//  - Four run-time modes: hold, shift, rotate, end-swap.
//  - Used as a configurable delay line and a circular test-pattern store.

---
 rtl/nb_shift_pipe_pkg.sv | 25 ++
 rtl/nb_pipe_stage.sv | 48 ++++
 rtl/nb_shift_pipe.sv | 95 +++++++++
 tb/tb_nb_shift_pipe.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/nb_shift_pipe_pkg.sv
// ============================================================================
// Module  : nb_shift_pipe_pkg
// Brief   : Mode and stage-select encodings shared by the shift pipe.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package nb_shift_pipe_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD   = 2'b00;
  localparam mode_t MODE_SHIFT  = 2'b01;
  localparam mode_t MODE_ROTATE = 2'b10;
  localparam mode_t MODE_SWAP   = 2'b11;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_HOLD = 2'b00;
  localparam sel_t SEL_PREV = 2'b01;
  localparam sel_t SEL_WRAP = 2'b10;

endpackage

`default_nettype wire

// File: rtl/nb_pipe_stage.sv
// ============================================================================
// Module  : nb_pipe_stage
// Brief   : One {valid, data} register with hold / previous / wrap next-value mux.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module nb_pipe_stage
  import nb_shift_pipe_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clr,
  input  sel_t           i_sel,
  input  logic [WIDTH:0] i_prev,
  input  logic [WIDTH:0] i_wrap,
  output logic [WIDTH:0] o_q
);

  logic [WIDTH:0] r_q;
  logic [WIDTH:0] w_next;

  always_comb begin
    w_next = r_q;
    case (i_sel)
      SEL_PREV: w_next = i_prev;
      SEL_WRAP: w_next = i_wrap;
      default:  w_next = r_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/nb_shift_pipe.sv
// ============================================================================
// Module  : nb_shift_pipe
// Brief   : DEPTH-stage register chain with hold, shift, rotate and end-swap modes.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module nb_shift_pipe
  import nb_shift_pipe_pkg::*;
#(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 3,
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               flush,
  input  mode_t              mode,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_valid,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [CNTW-1:0]    count
);

  // Each entry is {valid, data}
  logic [DEPTH-1:0][WIDTH:0] w_q;
  logic [CNTW-1:0]           r_count;
  logic [CNTW:0]             w_cnt_sum;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH:0] w_prev;
    logic [WIDTH:0] w_wrap;
    sel_t           w_sel;

    // Stage 0 wraps from the tail (rotate/swap); the tail wraps from stage 0 (swap)
    if (i == 0) begin : g_head
      assign w_prev = {din_valid, din};
      assign w_wrap = w_q[DEPTH-1];
    end else begin : g_body
      assign w_prev = w_q[i-1];
      assign w_wrap = w_q[0];
    end

    always_comb begin
      w_sel = SEL_HOLD;
      if (en) begin
        case (mode)
          MODE_SHIFT:  w_sel = SEL_PREV;
          MODE_ROTATE: w_sel = (i == 0) ? SEL_WRAP : SEL_PREV;
          MODE_SWAP:   w_sel = ((i == 0) || (i == DEPTH - 1)) ? SEL_WRAP : SEL_HOLD;
          default:     w_sel = SEL_HOLD;
        endcase
      end
    end

    nb_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (flush),
      .i_sel  (w_sel),
      .i_prev (w_prev),
      .i_wrap (w_wrap),
      .o_q    (w_q[i])
    );

    assign taps[i*WIDTH +: WIDTH] = w_q[i][WIDTH-1:0];
  end

  assign w_cnt_sum = {1'b0, r_count}
                   + {{CNTW{1'b0}}, din_valid}
                   - {{CNTW{1'b0}}, w_q[DEPTH-1][WIDTH]};

  // The MSB guard can only trip on an inconsistent count; it keeps the value in range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (en && (mode == MODE_SHIFT) && !w_cnt_sum[CNTW]) begin
      r_count <= w_cnt_sum[CNTW-1:0];
    end
  end

  assign count      = r_count;
  assign dout       = w_q[DEPTH-1][WIDTH-1:0];
  assign dout_valid = w_q[DEPTH-1][WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_nb_shift_pipe.sv
// ============================================================================
// Module  : tb_nb_shift_pipe
// Brief   : Vector table, corner sequences and random run against a queue-style model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nb_shift_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       flush;
  logic [1:0] mode;
  logic [1:0] din;
  logic       din_valid;

  logic [1:0] dout3;
  logic       dv3;
  logic [5:0] taps3;
  logic [1:0] count3;

  logic [1:0] dout1;
  logic       dv1;
  logic [1:0] taps1;
  logic [0:0] count1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nb_shift_pipe #(.WIDTH(2), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .mode(mode),
    .din(din), .din_valid(din_valid), .dout(dout3), .dout_valid(dv3),
    .taps(taps3), .count(count3)
  );

  nb_shift_pipe #(.WIDTH(2), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .mode(mode),
    .din(din), .din_valid(din_valid), .dout(dout1), .dout_valid(dv1),
    .taps(taps1), .count(count1)
  );

  // Reference state: index k=0 is the DEPTH=3 pipe, k=1 the DEPTH=1 pipe
  logic [1:0] md [2][3];
  bit         mv [2][3];
  int         mdep [2] = '{3, 1};

  function automatic void model_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 3; i++) begin
        md[k][i] = 2'b00;
        mv[k][i] = 1'b0;
      end
  endfunction

  function automatic void model_step(int k);
    int n = mdep[k];
    logic [1:0] td;
    bit tv;
    if (flush) begin
      for (int i = 0; i < n; i++) begin md[k][i] = 2'b00; mv[k][i] = 1'b0; end
    end else if (en) begin
      case (mode)
        2'b01: begin
          for (int i = n - 1; i > 0; i--) begin md[k][i] = md[k][i-1]; mv[k][i] = mv[k][i-1]; end
          md[k][0] = din;
          mv[k][0] = din_valid;
        end
        2'b10: begin
          td = md[k][n-1];
          tv = mv[k][n-1];
          for (int i = n - 1; i > 0; i--) begin md[k][i] = md[k][i-1]; mv[k][i] = mv[k][i-1]; end
          md[k][0] = td;
          mv[k][0] = tv;
        end
        2'b11: begin
          td = md[k][0];        tv = mv[k][0];
          md[k][0] = md[k][n-1]; mv[k][0] = mv[k][n-1];
          md[k][n-1] = td;       mv[k][n-1] = tv;
        end
        default: ;
      endcase
    end
  endfunction

  function automatic int model_count(int k);
    int c = 0;
    for (int i = 0; i < mdep[k]; i++) c += int'(mv[k][i]);
    return c;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick(input logic e, input logic f, input logic [1:0] m,
                      input logic [1:0] d, input logic dv);
    en = e; flush = f; mode = m; din = d; din_valid = dv;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       en;
    logic       flush;
    logic [1:0] mode;
    logic [1:0] din;
    logic       dv;
    logic [5:0] taps;
    logic [1:0] cnt;
    logic       dvo;
  } vec_t;

  vec_t vecs [18];

  initial begin
    // taps = {stage2, stage1, stage0}
    vecs[0]  = '{1'b1, 1'b0, 2'b01, 2'b01, 1'b1, 6'b00_00_01, 2'd1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'b01, 2'b10, 1'b1, 6'b00_01_10, 2'd2, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'b01, 2'b11, 1'b1, 6'b01_10_11, 2'd3, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 6'b10_11_01, 2'd3, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 6'b11_01_10, 2'd3, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 2'b10, 2'b01, 1'b1, 6'b01_10_11, 2'd3, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 6'b11_10_01, 2'd3, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 2'b11, 2'b11, 1'b1, 6'b01_10_11, 2'd3, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 6'b10_11_00, 2'd2, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 6'b11_00_00, 2'd1, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 6'b00_00_00, 2'd0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 2'b01, 2'b01, 1'b1, 6'b00_00_01, 2'd1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 2'b01, 2'b10, 1'b1, 6'b00_01_10, 2'd2, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 2'b01, 2'b11, 1'b1, 6'b01_10_11, 2'd3, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 2'b01, 2'b10, 1'b1, 6'b01_10_11, 2'd3, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 6'b01_10_11, 2'd3, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 6'b01_10_11, 2'd3, 1'b1};
    vecs[17] = '{1'b1, 1'b1, 2'b01, 2'b11, 1'b1, 6'b00_00_00, 2'd0, 1'b0};

    rst_n = 1'b0; en = 1'b0; flush = 1'b0; mode = 2'b00; din = 2'b00; din_valid = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check("reset_taps3", 32'(taps3), 32'h0);
    check("reset_count3", 32'(count3), 32'h0);
    check("reset_dv3", 32'(dv3), 32'h0);
    check("reset_dout1", 32'(dout1), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      tick(vecs[i].en, vecs[i].flush, vecs[i].mode, vecs[i].din, vecs[i].dv);
      check($sformatf("vec%0d_taps", i), 32'(taps3), 32'(vecs[i].taps));
      check($sformatf("vec%0d_count", i), 32'(count3), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_dvalid", i), 32'(dv3), 32'(vecs[i].dvo));
      check($sformatf("vec%0d_dout", i), 32'(dout3), 32'(vecs[i].taps[5:4]));
    end

    // Asynchronous reset with the pipe full, then a normal first edge
    tick(1'b1, 1'b0, 2'b01, 2'b01, 1'b1);
    tick(1'b1, 1'b0, 2'b01, 2'b10, 1'b1);
    tick(1'b1, 1'b0, 2'b01, 2'b11, 1'b1);
    check("full_before_reset", 32'(taps3), 32'h1B);
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("async_rst_taps", 32'(taps3), 32'h0);
    check("async_rst_count", 32'(count3), 32'h0);
    check("async_rst_dv", 32'(dv3), 32'h0);
    check("async_rst_dout1", 32'(dout1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 2'b01, 2'b10, 1'b1);
    check("post_rst_taps", 32'(taps3), 32'h02);
    check("post_rst_count", 32'(count3), 32'h1);

    // DEPTH=1: rotate and swap are no-ops
    tick(1'b1, 1'b0, 2'b01, 2'b11, 1'b1);
    check("d1_shift_dout", 32'(dout1), 32'h3);
    check("d1_shift_count", 32'(count1), 32'h1);
    tick(1'b1, 1'b0, 2'b10, 2'b00, 1'b0);
    check("d1_rotate_dout", 32'(dout1), 32'h3);
    check("d1_rotate_dv", 32'(dv1), 32'h1);
    tick(1'b1, 1'b0, 2'b11, 2'b01, 1'b0);
    check("d1_swap_dout", 32'(dout1), 32'h3);
    check("d1_swap_count", 32'(count1), 32'h1);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("rand_async_rst", 32'(taps3), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      tick(($urandom_range(0, 9) != 0), ($urandom_range(0, 24) == 0),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      check("rand_taps3", 32'(taps3), 32'({md[0][2], md[0][1], md[0][0]}));
      check("rand_count3", 32'(count3), 32'(model_count(0)));
      check("rand_dv3", 32'(dv3), 32'(mv[0][2]));
      check("rand_dout1", 32'(dout1), 32'(md[1][0]));
      check("rand_dv1", 32'(dv1), 32'(mv[1][0]));
      check("rand_count1", 32'(count1), 32'(model_count(1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
